// File: rtl/sim_spi_ram_sync.sv
// Serial SPI SRAM model that oversamples the SPI pins with the system clock.
// Commands: 03h read, 0Bh fast read, 02h write, 05h/01h mode register read/write.
module sim_spi_ram_sync #(
    parameter int          ADDR_BYTES  = 3,
    parameter int          DEPTH_BYTES = 131072,
    parameter int          PAGE_BYTES  = 32,
    parameter logic [7:0]  MODE_RESET  = 8'h40,
    parameter              INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           spi_clk,
    input  logic                           spi_mosi,
    input  logic                           spi_select,
    output logic                           spi_miso,
    input  logic [$clog2(DEPTH_BYTES)-3:0] debug_addr,
    output logic [31:0]                    debug_data
);
    localparam int            AW    = $clog2(DEPTH_BYTES);
    localparam int            WORDS = DEPTH_BYTES / 4;
    localparam logic [AW-1:0] PMASK = AW'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_MODE_RD, S_MODE_WR, S_ERR
    } state_t;

    logic [2:0]    sclk_sync_q;
    logic [1:0]    mosi_sync_q, sel_sync_q;
    logic          armed_q, armed_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    mode_q, mode_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [1:0]    abyte_cnt_q, abyte_cnt_d;
    logic [2:0]    rd_cnt_q, rd_cnt_d;
    logic          miso_q, miso_d;
    logic          mem_we;

    logic            rise, fall, byte_done, byte_mode;
    logic [7:0]      rx_byte, rd_byte;
    logic [AW-1:0]   addr_next;
    logic [AW+7:0]   addr_shift;
    logic [31:0]     rd_word, dbg_word;

    assign rise       = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fall       = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign rx_byte    = {shift_q, mosi_sync_q[1]};
    assign byte_done  = rise && (bit_cnt_q == 3'd7);
    assign byte_mode  = (mode_q[7:6] == 2'b00);
    assign addr_next  = (mode_q[7:6] == 2'b10)
                        ? ((addr_q & ~PMASK) | ((addr_q + AW'(1)) & PMASK))
                        : (addr_q + AW'(1));
    // The first address byte starts from zero so short addresses never keep stale high bits.
    assign addr_shift = {((abyte_cnt_q == 2'd0) ? {AW{1'b0}} : addr_q), rx_byte};
    assign rd_byte    = rd_word[{addr_q[1:0], 3'b000} +: 8];

    always_comb begin
        armed_d     = armed_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        cmd_d       = cmd_q;
        abyte_cnt_d = abyte_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        miso_d      = miso_q;
        mem_we      = 1'b0;
        if (sel_sync_q[1]) begin
            armed_d   = 1'b1;
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
            miso_d    = 1'b0;
        end else if (armed_q) begin
            if (rise) begin
                shift_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                S_CMD: if (byte_done) begin
                    cmd_d       = rx_byte;
                    abyte_cnt_d = 2'd0;
                    rd_cnt_d    = 3'd0;
                    case (rx_byte)
                        8'h03, 8'h0B, 8'h02: state_d = S_ADDR;
                        8'h05:               state_d = S_MODE_RD;
                        8'h01:               state_d = S_MODE_WR;
                        default:             state_d = S_ERR;
                    endcase
                end
                S_ADDR: if (byte_done) begin
                    addr_d      = addr_shift[AW-1:0];
                    abyte_cnt_d = abyte_cnt_q + 2'd1;
                    if (abyte_cnt_q == 2'(ADDR_BYTES - 1)) begin
                        rd_cnt_d = 3'd0;
                        case (cmd_q)
                            8'h03:   state_d = S_READ;
                            8'h0B:   state_d = S_DUMMY;
                            default: state_d = S_WRITE;
                        endcase
                    end
                end
                S_DUMMY: if (byte_done) begin
                    state_d  = S_READ;
                    rd_cnt_d = 3'd0;
                end
                S_READ: if (fall) begin
                    miso_d   = rd_byte[3'd7 - rd_cnt_q];
                    rd_cnt_d = rd_cnt_q + 3'd1;
                    if (rd_cnt_q == 3'd7) begin
                        if (byte_mode) state_d = S_ERR;
                        else           addr_d  = addr_next;
                    end
                end
                S_WRITE: if (byte_done) begin
                    mem_we = 1'b1;
                    if (byte_mode) state_d = S_ERR;
                    else           addr_d  = addr_next;
                end
                S_MODE_RD: if (fall) begin
                    miso_d   = mode_q[3'd7 - rd_cnt_q];
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
                S_MODE_WR: if (byte_done) begin
                    mode_d  = rx_byte;
                    state_d = S_ERR;
                end
                default: miso_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= 3'd0;
            mosi_sync_q <= 2'd0;
            sel_sync_q  <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= S_CMD;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            addr_q      <= '0;
            mode_q      <= MODE_RESET;
            cmd_q       <= 8'd0;
            abyte_cnt_q <= 2'd0;
            rd_cnt_q    <= 3'd0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sel_sync_q  <= {sel_sync_q[0], spi_select};
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            cmd_q       <= cmd_d;
            abyte_cnt_q <= abyte_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            miso_q      <= miso_d;
        end
    end

    // One byte lane per word byte: each lane has one write port and two read ports.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_q, dbg_q;

        always_ff @(posedge clk) begin
            if (mem_we && (addr_q[1:0] == 2'(gi)))
                mem[addr_q[AW-1:2]] <= rx_byte;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q  <= 8'd0;
                dbg_q <= 8'd0;
            end else begin
                rd_q  <= mem[addr_q[AW-1:2]];
                dbg_q <= mem[debug_addr];
            end
        end

        assign rd_word[8*gi +: 8]  = rd_q;
        assign dbg_word[8*gi +: 8] = dbg_q;
    end

    assign spi_miso   = miso_q;
    assign debug_data = dbg_word;
endmodule

// File: tb/tb_sim_spi_ram_sync.sv
// Scoreboard bench for sim_spi_ram_sync: SPI master tasks push expected bytes/words
// from a byte-array memory model; a monitor compares every observed response.
module tb_sim_spi_ram_sync;
    localparam int ADDR_BYTES = 3;
    localparam int DEPTH      = 131072;
    localparam int PAGE       = 32;

    logic        clk = 1'b0;
    logic        rst, spi_clk, spi_mosi, spi_select, spi_miso;
    logic [14:0] debug_addr;
    logic [31:0] debug_data;

    sim_spi_ram_sync dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_select(spi_select), .spi_miso(spi_miso),
        .debug_addr(debug_addr), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] exp; bit known; } exp_t;
    exp_t        sb_q[$];
    int          checks = 0, errors = 0;
    logic        obs_valid = 1'b0;
    logic [31:0] obs_data  = 32'd0;

    // Reference model: flat byte memory plus mode register.
    logic [7:0] mm [int];
    logic [7:0] mode_m = 8'h40;

    function automatic int adv(input int a);
        if (mode_m[7:6] == 2'b10) return (a - (a % PAGE)) + ((a + 1) % PAGE);
        return (a + 1) % DEPTH;
    endfunction

    always @(negedge clk) begin
        if (obs_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: got %h, want nothing queued", obs_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.known) begin
                    checks++;
                    if (obs_data !== e.exp) begin
                        errors++;
                        $display("FAIL %s: got %h, want %h", e.name, obs_data, e.exp);
                    end else
                        $display("check %s: %h ok", e.name, obs_data);
                end
            end
        end
    end

    task automatic push(input string n, input logic [31:0] v, input bit k);
        exp_t x;
        x.name = n; x.exp = v; x.known = k;
        sb_q.push_back(x);
    endtask

    task automatic observe(input logic [31:0] d);
        @(posedge clk); #1;
        obs_data = d; obs_valid = 1'b1;
        @(posedge clk); #1;
        obs_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (5) @(posedge clk); #2;
            rx[7-i] = spi_miso;
            spi_clk = 1'b1;
            repeat (5) @(posedge clk); #2;
            spi_clk = 1'b0;
        end
    endtask

    task automatic sel_begin();
        spi_select = 1'b0;
        repeat (4) @(posedge clk); #2;
    endtask

    task automatic sel_end();
        repeat (3) @(posedge clk); #2;
        spi_select = 1'b1; spi_mosi = 1'b0;
        repeat (6) @(posedge clk); #2;
    endtask

    task automatic send_addr(input int a);
        logic [7:0] rx, b;
        for (int i = ADDR_BYTES - 1; i >= 0; i--) begin
            b = 8'(a >> (8 * i));
            xfer(b, 8, rx);
        end
    endtask

    task automatic do_write(input int addr, input logic [7:0] d[$]);
        logic [7:0] rx;
        int a = addr;
        sel_begin();
        xfer(8'h02, 8, rx);
        send_addr(addr);
        for (int k = 0; k < d.size(); k++) begin
            xfer(d[k], 8, rx);
            if (!(mode_m[7:6] == 2'b00 && k > 0)) begin
                mm[a] = d[k];
                a = adv(a);
            end
        end
        sel_end();
    endtask

    task automatic do_read(input logic [7:0] cmd, input int addr, input int n, input string tag);
        logic [7:0] rx;
        int a = addr;
        sel_begin();
        xfer(cmd, 8, rx);
        send_addr(addr);
        if (cmd == 8'h0B) begin
            push("dummy_miso", 32'd0, 1'b1);
            xfer(8'hFF, 8, rx);
            observe({24'd0, rx});
        end
        for (int k = 0; k < n; k++) begin
            if (mode_m[7:6] == 2'b00 && k > 0) push(tag, 32'd0, 1'b1);
            else if (mm.exists(a))             push(tag, {24'd0, mm[a]}, 1'b1);
            else                               push(tag, 32'd0, 1'b0);
            xfer(8'h00, 8, rx);
            observe({24'd0, rx});
            a = adv(a);
        end
        sel_end();
    endtask

    task automatic mode_wr(input logic [7:0] m);
        logic [7:0] rx;
        sel_begin();
        xfer(8'h01, 8, rx);
        xfer(m, 8, rx);
        sel_end();
        mode_m = m;
    endtask

    task automatic mode_rd(input int n);
        logic [7:0] rx;
        sel_begin();
        xfer(8'h05, 8, rx);
        for (int k = 0; k < n; k++) begin
            push("mode_rd", {24'd0, mode_m}, 1'b1);
            xfer(8'h00, 8, rx);
            observe({24'd0, rx});
        end
        sel_end();
    endtask

    task automatic dbg_check(input int w, input string tag);
        logic [31:0] d;
        int b = w * 4;
        bit k = mm.exists(b) && mm.exists(b+1) && mm.exists(b+2) && mm.exists(b+3);
        debug_addr = 15'(w);
        repeat (2) @(posedge clk); #1;
        d = debug_data;
        if (k) push(tag, {mm[b+3], mm[b+2], mm[b+1], mm[b]}, 1'b1);
        else   push(tag, 32'd0, 1'b0);
        observe(d);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] rx;
        rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_select = 1'b1; debug_addr = 15'd0;
        repeat (3) @(posedge clk); #2;
        push("reset_miso", 32'd0, 1'b1);
        observe({31'd0, spi_miso});
        push("reset_debug", 32'd0, 1'b1);
        observe(debug_data);
        rst = 1'b0;
        repeat (4) @(posedge clk); #2;

        // Known background for the low 64 bytes.
        d = {};
        for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
        do_write(0, d);

        d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_write(32'h100, d);
        do_read(8'h03, 32'h100, 4, "read_deadbeef");
        dbg_check(32'h40, "debug_40");
        do_read(8'h0B, 32'h100, 2, "fast_read");

        mode_wr(8'h80);
        d = {8'h11, 8'h22};
        do_write(32'h1F, d);
        dbg_check(7, "page_1f");
        dbg_check(0, "page_wrap_00");
        dbg_check(8, "page_20_kept");
        mode_rd(1);

        mode_wr(8'h00);
        d = {8'hAA, 8'hBB};
        do_write(5, d);
        dbg_check(1, "bytemode_5_6");
        do_read(8'h03, 5, 2, "bytemode_read");

        mode_wr(8'h40);
        d = {8'h12, 8'h34};
        do_write(32'h1FFFF, d);
        dbg_check(32'h7FFF, "seq_wrap_top");
        dbg_check(0, "seq_wrap_0");

        // Deselect in the middle of a data byte.
        sel_begin();
        xfer(8'h02, 8, rx);
        send_addr(32'h10);
        xfer(8'h5A, 5, rx);
        sel_end();
        dbg_check(4, "abort_kept");

        // Unknown command.
        sel_begin();
        push("err_cmd", 32'd0, 1'b1);
        xfer(8'h9F, 8, rx);
        observe({24'd0, rx});
        for (int k = 0; k < 4; k++) begin
            push("err_miso", 32'd0, 1'b1);
            xfer(8'($urandom), 8, rx);
            observe({24'd0, rx});
        end
        sel_end();

        for (int it = 0; it < 25; it++) begin
            int sel = $urandom_range(0, 7);
            if (sel == 0) mode_wr(8'h00 | 8'($urandom_range(0, 63)));
            else if (sel < 3) mode_wr(8'h80 | 8'($urandom_range(0, 63)));
            else if (sel == 3) mode_wr(8'hC0);
            else if (sel == 4) mode_wr(8'h40);
            d = {};
            for (int i = 0; i < $urandom_range(1, 4); i++) d.push_back(8'($urandom));
            do_write($urandom_range(0, 63), d);
            do_read(($urandom_range(0, 1) != 0) ? 8'h0B : 8'h03,
                    $urandom_range(0, 63), $urandom_range(1, 4), "rand_read");
            dbg_check($urandom_range(0, 15), "rand_debug");
        end
        mode_rd(2);

        // Reset pulse in the middle of a read.
        mode_wr(8'hC0);
        sel_begin();
        xfer(8'h03, 8, rx);
        send_addr(32'h100);
        xfer(8'h00, 3, rx);
        #3 rst = 1'b1;
        #1;
        push("rst_miso", 32'd0, 1'b1);
        rx = {7'd0, spi_miso};
        mode_m = 8'h40;
        repeat (2) @(posedge clk); #2;
        rst = 1'b0;
        observe({24'd0, rx});
        push("post_rst_ignored", 32'd0, 1'b1);
        xfer(8'h00, 8, rx);
        observe({24'd0, rx});
        sel_end();
        mode_rd(1);

        repeat (4) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
